// File: rtl/midi_decoder_pkg.sv
// Shared MIDI command codes, status-nibble constants, parser states and the
// status-to-data-length helper used by the decoder and its classifier.
package midi_decoder_pkg;

  localparam int MIDI_CMD_SIZE = 4;

  localparam logic [3:0] MIDI_CMD_NONE        = 4'd0;
  localparam logic [3:0] MIDI_CMD_NOTE_OFF    = 4'd1;
  localparam logic [3:0] MIDI_CMD_NOTE_ON     = 4'd2;
  localparam logic [3:0] MIDI_CMD_AFTERTOUCH  = 4'd3;
  localparam logic [3:0] MIDI_CMD_CTRL_CHG    = 4'd4;
  localparam logic [3:0] MIDI_CMD_PATCH_CHG   = 4'd5;
  localparam logic [3:0] MIDI_CMD_CH_PRESSURE = 4'd6;
  localparam logic [3:0] MIDI_CMD_PITCH_BEND  = 4'd7;
  localparam logic [3:0] MIDI_CMD_SYS_COMMON  = 4'd8;
  localparam logic [3:0] MIDI_CMD_SYS_RT      = 4'd9;

  localparam logic [3:0] ST_NOTE_OFF    = 4'h8;
  localparam logic [3:0] ST_NOTE_ON     = 4'h9;
  localparam logic [3:0] ST_AFTERTOUCH  = 4'hA;
  localparam logic [3:0] ST_CTRL_CHG    = 4'hB;
  localparam logic [3:0] ST_PATCH_CHG   = 4'hC;
  localparam logic [3:0] ST_CH_PRESSURE = 4'hD;
  localparam logic [3:0] ST_PITCH_BEND  = 4'hE;
  localparam logic [3:0] ST_SYSTEM      = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D0 = 2'd1,
    S_WAIT_D1 = 2'd2,
    S_SYSEX   = 2'd3
  } state_e;

  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      ST_NOTE_OFF, ST_NOTE_ON, ST_AFTERTOUCH, ST_CTRL_CHG, ST_PITCH_BEND: len = 2'd2;
      ST_PATCH_CHG, ST_CH_PRESSURE: len = 2'd1;
      ST_SYSTEM: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_decoder_classify.sv
// Combinational status-byte classifier: command code, data-byte count and
// the special-status flags the decoder FSM branches on.
module midi_decoder_classify
  import midi_decoder_pkg::*;
(
  input  logic [7:0] status_i,
  output logic [3:0] cmd_o,
  output logic [1:0] nbytes_o,
  output logic       is_rt_o,
  output logic       is_sysex_start_o,
  output logic       is_sysex_end_o,
  output logic       is_undef_o
);

  always_comb begin
    cmd_o            = MIDI_CMD_NONE;
    nbytes_o         = data_len(status_i);
    is_rt_o          = 1'b0;
    is_sysex_start_o = 1'b0;
    is_sysex_end_o   = 1'b0;
    is_undef_o       = 1'b0;
    case (status_i[7:4])
      ST_NOTE_OFF:    cmd_o = MIDI_CMD_NOTE_OFF;
      ST_NOTE_ON:     cmd_o = MIDI_CMD_NOTE_ON;
      ST_AFTERTOUCH:  cmd_o = MIDI_CMD_AFTERTOUCH;
      ST_CTRL_CHG:    cmd_o = MIDI_CMD_CTRL_CHG;
      ST_PATCH_CHG:   cmd_o = MIDI_CMD_PATCH_CHG;
      ST_CH_PRESSURE: cmd_o = MIDI_CMD_CH_PRESSURE;
      ST_PITCH_BEND:  cmd_o = MIDI_CMD_PITCH_BEND;
      ST_SYSTEM: begin
        // F8-FF are real-time; F0-F7 are system common / exclusive
        if (status_i[3]) begin
          cmd_o   = MIDI_CMD_SYS_RT;
          is_rt_o = 1'b1;
        end else begin
          cmd_o            = MIDI_CMD_SYS_COMMON;
          is_sysex_start_o = (status_i[3:0] == 4'h0);
          is_sysex_end_o   = (status_i[3:0] == 4'h7);
          is_undef_o       = (status_i[3:0] == 4'h4) || (status_i[3:0] == 4'h5);
        end
      end
      default: cmd_o = MIDI_CMD_NONE;
    endcase
  end

endmodule

// File: rtl/midi_decoder.sv
// MIDI byte-stream parser: running status, real-time interleaving, SysEx
// skipping, optional channel filter; emits registered one-cycle messages.
module midi_decoder
  import midi_decoder_pkg::*;
#(
  parameter bit         OMNI        = 1'b1,
  parameter logic [3:0] CHANNEL     = 4'd0,
  parameter bit         VEL0_IS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_rdy,
  input  logic [7:0] byte_data,
  output logic       midi_rdy,
  output logic [3:0] midi_cmd,
  output logic [3:0] midi_ch_sysn,
  output logic [6:0] midi_data0,
  output logic [6:0] midi_data1,
  output logic       err
);

  state_e     state_q, state_d;
  logic [3:0] st_cmd_q, st_cmd_d;
  logic [3:0] st_ch_q, st_ch_d;
  logic       st_two_q, st_two_d;
  logic       st_sys_q, st_sys_d;
  logic [6:0] data0_q, data0_d;

  logic       rdy_q, err_q, err_d;
  logic [3:0] cmd_q, ch_q;
  logic [6:0] d0_q, d1_q;

  logic [3:0] cls_cmd;
  logic [1:0] cls_len;
  logic       cls_rt, cls_sx_start, cls_sx_end, cls_undef;

  logic       emit;
  logic [3:0] e_cmd, e_ch, o_cmd;
  logic [6:0] e_d0, e_d1;
  logic       e_voice, rdy_d;

  midi_decoder_classify u_classify (
    .status_i         (byte_data),
    .cmd_o            (cls_cmd),
    .nbytes_o         (cls_len),
    .is_rt_o          (cls_rt),
    .is_sysex_start_o (cls_sx_start),
    .is_sysex_end_o   (cls_sx_end),
    .is_undef_o       (cls_undef)
  );

  always_comb begin
    state_d  = state_q;
    st_cmd_d = st_cmd_q;
    st_ch_d  = st_ch_q;
    st_two_d = st_two_q;
    st_sys_d = st_sys_q;
    data0_d  = data0_q;
    err_d    = 1'b0;
    emit     = 1'b0;
    e_cmd    = MIDI_CMD_NONE;
    e_ch     = 4'd0;
    e_d0     = 7'd0;
    e_d1     = 7'd0;
    if (byte_rdy) begin
      if (cls_rt) begin
        // Real-time bytes leave parser state and running status untouched
        emit  = 1'b1;
        e_cmd = MIDI_CMD_SYS_RT;
        e_ch  = byte_data[3:0];
      end else if (byte_data[7]) begin
        if (state_q == S_SYSEX && cls_sx_end) begin
          state_d = S_IDLE;
        end else begin
          if (state_q == S_WAIT_D1 || (state_q == S_WAIT_D0 && st_sys_q))
            err_d = 1'b1;
          if (cls_undef || cls_sx_end) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cls_sx_start) begin
            state_d = S_SYSEX;
          end else if (cls_len == 2'd0) begin
            emit    = 1'b1;
            e_cmd   = cls_cmd;
            e_ch    = byte_data[3:0];
            state_d = S_IDLE;
          end else begin
            st_cmd_d = cls_cmd;
            st_ch_d  = byte_data[3:0];
            st_two_d = (cls_len == 2'd2);
            st_sys_d = (byte_data[7:4] == ST_SYSTEM);
            state_d  = S_WAIT_D0;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: err_d = 1'b1;
          S_WAIT_D0: begin
            if (st_two_q) begin
              data0_d = byte_data[6:0];
              state_d = S_WAIT_D1;
            end else begin
              emit    = 1'b1;
              e_cmd   = st_cmd_q;
              e_ch    = st_ch_q;
              e_d0    = byte_data[6:0];
              state_d = st_sys_q ? S_IDLE : S_WAIT_D0;
            end
          end
          S_WAIT_D1: begin
            emit    = 1'b1;
            e_cmd   = st_cmd_q;
            e_ch    = st_ch_q;
            e_d0    = data0_q;
            e_d1    = byte_data[6:0];
            state_d = st_sys_q ? S_IDLE : S_WAIT_D0;
          end
          default: ;
        endcase
      end
    end
  end

  assign e_voice = (e_cmd >= MIDI_CMD_NOTE_OFF) && (e_cmd <= MIDI_CMD_PITCH_BEND);
  assign o_cmd   = (VEL0_IS_OFF && e_cmd == MIDI_CMD_NOTE_ON && e_d1 == 7'd0)
                   ? MIDI_CMD_NOTE_OFF : e_cmd;
  // Filtered voice messages are still parsed; only the strobe is withheld
  assign rdy_d   = emit && (OMNI || !e_voice || e_ch == CHANNEL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      st_cmd_q <= MIDI_CMD_NONE;
      st_ch_q  <= 4'd0;
      st_two_q <= 1'b0;
      st_sys_q <= 1'b0;
      data0_q  <= 7'd0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      cmd_q    <= MIDI_CMD_NONE;
      ch_q     <= 4'd0;
      d0_q     <= 7'd0;
      d1_q     <= 7'd0;
    end else begin
      state_q  <= state_d;
      st_cmd_q <= st_cmd_d;
      st_ch_q  <= st_ch_d;
      st_two_q <= st_two_d;
      st_sys_q <= st_sys_d;
      data0_q  <= data0_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      if (rdy_d) begin
        cmd_q <= o_cmd;
        ch_q  <= e_ch;
        d0_q  <= e_d0;
        d1_q  <= e_d1;
      end
    end
  end

  assign midi_rdy     = rdy_q;
  assign err          = err_q;
  assign midi_cmd     = cmd_q;
  assign midi_ch_sysn = ch_q;
  assign midi_data0   = d0_q;
  assign midi_data1   = d1_q;

endmodule

// File: tb/tb_midi_decoder.sv
// Directed byte-stream bench for midi_decoder: an omni instance and a
// channel-3 filtered instance share one input stream.
module tb_midi_decoder;

  logic       clk;
  logic       reset;
  logic       byte_rdy;
  logic [7:0] byte_data;

  logic       midi_rdy, err;
  logic [3:0] midi_cmd, midi_ch_sysn;
  logic [6:0] midi_data0, midi_data1;

  logic       f_rdy, f_err;
  logic [3:0] f_cmd, f_ch;
  logic [6:0] f_d0, f_d1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] b;
    logic       rdy;
    logic       rdy_f;
    logic       err;
    logic [3:0] cmd;
    logic [3:0] ch;
    logic [6:0] d0;
    logic [6:0] d1;
  } vec_t;

  vec_t tbl[$];

  midi_decoder #(.OMNI(1'b1), .CHANNEL(4'd0), .VEL0_IS_OFF(1'b1)) dut (
    .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .byte_data(byte_data),
    .midi_rdy(midi_rdy), .midi_cmd(midi_cmd), .midi_ch_sysn(midi_ch_sysn),
    .midi_data0(midi_data0), .midi_data1(midi_data1), .err(err)
  );

  midi_decoder #(.OMNI(1'b0), .CHANNEL(4'd3), .VEL0_IS_OFF(1'b1)) dut_f (
    .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .byte_data(byte_data),
    .midi_rdy(f_rdy), .midi_cmd(f_cmd), .midi_ch_sysn(f_ch),
    .midi_data0(f_d0), .midi_data1(f_d1), .err(f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [7:0] b, input logic rdy, input logic rdy_f, input logic e,
                     input logic [3:0] cmd, input logic [3:0] ch,
                     input logic [6:0] d0, input logic [6:0] d1);
    vec_t v;
    v.b = b; v.rdy = rdy; v.rdy_f = rdy_f; v.err = e;
    v.cmd = cmd; v.ch = ch; v.d0 = d0; v.d1 = d1;
    tbl.push_back(v);
  endtask

  // b, rdy, rdy_f, err, cmd, ch, d0, d1
  task automatic fill_table();
    add(8'h3C, 0, 0, 1, 0, 0, 0, 0);           // leading data byte
    add(8'h90, 0, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 0, 0, 0, 0, 0, 0, 0);
    add(8'h64, 1, 0, 0, 2, 0, 7'h3C, 7'h64);
    add(8'h91, 0, 0, 0, 0, 0, 0, 0);
    add(8'h40, 0, 0, 0, 0, 0, 0, 0);
    add(8'h7F, 1, 0, 0, 2, 1, 7'h40, 7'h7F);
    add(8'h41, 0, 0, 0, 0, 0, 0, 0);           // running status
    add(8'h00, 1, 0, 0, 1, 1, 7'h41, 7'h00);   // velocity 0 -> NOTE_OFF
    add(8'hB2, 0, 0, 0, 0, 0, 0, 0);
    add(8'h07, 0, 0, 0, 0, 0, 0, 0);
    add(8'hF8, 1, 1, 0, 9, 8, 0, 0);           // real-time mid-message
    add(8'h50, 1, 0, 0, 4, 2, 7'h07, 7'h50);
    add(8'hC5, 0, 0, 0, 0, 0, 0, 0);
    add(8'h0A, 1, 0, 0, 5, 5, 7'h0A, 7'h00);
    add(8'hF0, 0, 0, 0, 0, 0, 0, 0);
    add(8'h01, 0, 0, 0, 0, 0, 0, 0);
    add(8'h02, 0, 0, 0, 0, 0, 0, 0);
    add(8'hF7, 0, 0, 0, 0, 0, 0, 0);
    add(8'hD5, 0, 0, 0, 0, 0, 0, 0);
    add(8'h33, 1, 0, 0, 6, 5, 7'h33, 7'h00);
    add(8'h80, 0, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 0, 0, 0, 0, 0, 0, 0);
    add(8'h90, 0, 0, 1, 0, 0, 0, 0);           // interrupts WAIT_D1
    add(8'h3C, 0, 0, 0, 0, 0, 0, 0);
    add(8'h10, 1, 0, 0, 2, 0, 7'h3C, 7'h10);
    add(8'h93, 0, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 0, 0, 0, 0, 0, 0, 0);
    add(8'h64, 1, 1, 0, 2, 3, 7'h3C, 7'h64);   // passes channel filter
    add(8'h92, 0, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 0, 0, 0, 0, 0, 0, 0);
    add(8'h64, 1, 0, 0, 2, 2, 7'h3C, 7'h64);   // filtered on channel 2
    add(8'hF2, 0, 0, 0, 0, 0, 0, 0);
    add(8'h11, 0, 0, 0, 0, 0, 0, 0);
    add(8'h22, 1, 1, 0, 8, 2, 7'h11, 7'h22);
    add(8'h40, 0, 0, 1, 0, 0, 0, 0);           // system msg cleared running status
    add(8'hF6, 1, 1, 0, 8, 6, 0, 0);
    add(8'hF4, 0, 0, 1, 0, 0, 0, 0);
    add(8'hF7, 0, 0, 1, 0, 0, 0, 0);
    add(8'hE0, 0, 0, 0, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(8'h40, 1, 0, 0, 7, 0, 7'h00, 7'h40);
    add(8'hF1, 0, 0, 0, 0, 0, 0, 0);
    add(8'h90, 0, 0, 1, 0, 0, 0, 0);           // partial system message dropped
    add(8'h3C, 0, 0, 0, 0, 0, 0, 0);
    add(8'h00, 1, 0, 0, 1, 0, 7'h3C, 7'h00);
    add(8'hA4, 0, 0, 0, 0, 0, 0, 0);
    add(8'h01, 0, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 0, 0, 1, 0, 0, 0, 0);
    add(8'h05, 0, 0, 0, 0, 0, 0, 0);
    add(8'hC3, 0, 0, 0, 0, 0, 0, 0);           // status ends SysEx silently
    add(8'h09, 1, 1, 0, 5, 3, 7'h09, 7'h00);
  endtask

  initial begin
    reset     = 1'b0;
    byte_rdy  = 1'b0;
    byte_data = 8'h00;
    fill_table();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", 32'(midi_rdy), 0);
    check("reset_err", 32'(err), 0);
    check("reset_cmd", 32'(midi_cmd), 0);
    check("reset_ch",  32'(midi_ch_sysn), 0);
    check("reset_d0",  32'(midi_data0), 0);
    check("reset_d1",  32'(midi_data1), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      byte_rdy  = 1'b1;
      byte_data = tbl[i].b;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rdy", i), 32'(midi_rdy), 32'(tbl[i].rdy));
      check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
      check($sformatf("v%0d_rdy_f", i), 32'(f_rdy), 32'(tbl[i].rdy_f));
      if (tbl[i].rdy) begin
        check($sformatf("v%0d_cmd", i), 32'(midi_cmd), 32'(tbl[i].cmd));
        check($sformatf("v%0d_ch", i), 32'(midi_ch_sysn), 32'(tbl[i].ch));
        check($sformatf("v%0d_d0", i), 32'(midi_data0), 32'(tbl[i].d0));
        check($sformatf("v%0d_d1", i), 32'(midi_data1), 32'(tbl[i].d1));
      end
    end

    // Strobe lasts one cycle; fields hold
    @(negedge clk);
    byte_rdy = 1'b0;
    @(posedge clk);
    #1;
    check("hold_rdy", 32'(midi_rdy), 0);
    check("hold_err", 32'(err), 0);
    check("hold_cmd", 32'(midi_cmd), 5);
    check("hold_ch",  32'(midi_ch_sysn), 3);
    check("hold_d0",  32'(midi_data0), 7'h09);

    // Channel-filtered instance keeps its last delivered fields
    check("filt_cmd", 32'(f_cmd), 5);
    check("filt_ch",  32'(f_ch), 3);

    // Asynchronous reset between a status byte and its data
    @(negedge clk);
    byte_rdy  = 1'b1;
    byte_data = 8'h95;
    @(negedge clk);
    byte_rdy = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("areset_cmd", 32'(midi_cmd), 0);
    check("areset_ch",  32'(midi_ch_sysn), 0);
    check("areset_d0",  32'(midi_data0), 0);
    check("areset_d1",  32'(midi_data1), 0);
    check("areset_rdy", 32'(midi_rdy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    byte_rdy  = 1'b1;
    byte_data = 8'h3C;
    @(posedge clk);
    #1;
    check("post_reset_err", 32'(err), 1);
    check("post_reset_rdy", 32'(midi_rdy), 0);
    @(negedge clk);
    byte_rdy = 1'b0;
    @(posedge clk);
    #1;
    check("err_one_cycle", 32'(err), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
